// File: rtl/r2sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: buffers half a block, emits saturated sums then differences.
// Registered outputs, one cycle after each accepted sample; no backpressure, bubbles freeze all state.
package r2sdf_pkg;
  localparam int DATA_WIDTH = 16;
  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] data_r;
    logic signed [DATA_WIDTH-1:0] data_i;
  } data_sample_t;
endpackage

module r2sdf_bf_stage
  import r2sdf_pkg::*;
#(
  parameter  int DELAY = 8,
  localparam int IW    = (DELAY > 1) ? $clog2(DELAY) : 1,
  localparam int CW    = $clog2(2 * DELAY)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  data_sample_t  in_data,
  output logic          out_valid,
  output data_sample_t  out_data,
  output logic          out_phase,
  output logic [IW-1:0] out_idx
);

  logic [CW-1:0] cnt_q;
  logic          primed_q;
  data_sample_t  mem_q [DELAY];
  logic          out_valid_q;
  data_sample_t  out_data_q;
  logic          out_phase_q;
  logic [IW-1:0] out_idx_q;

  logic          half;
  logic [IW-1:0] idx;
  data_sample_t  head;
  data_sample_t  sum_d;
  data_sample_t  diff_d;
  data_sample_t  wr_d;
  data_sample_t  out_data_d;

  // Overflow of a 17-bit sum/difference shows up as disagreement of its top two bits.
  function automatic logic signed [DATA_WIDTH-1:0] sat16(input logic signed [DATA_WIDTH:0] v);
    logic signed [DATA_WIDTH-1:0] r;
    if (v[DATA_WIDTH] != v[DATA_WIDTH-1])
      r = v[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      r = v[DATA_WIDTH-1:0];
    return r;
  endfunction

  assign half = (cnt_q >= CW'(DELAY));
  assign idx  = IW'(cnt_q % CW'(DELAY));
  assign head = mem_q[idx];

  always_comb begin
    sum_d.data_r  = sat16({head.data_r[DATA_WIDTH-1], head.data_r} + {in_data.data_r[DATA_WIDTH-1], in_data.data_r});
    sum_d.data_i  = sat16({head.data_i[DATA_WIDTH-1], head.data_i} + {in_data.data_i[DATA_WIDTH-1], in_data.data_i});
    diff_d.data_r = sat16({head.data_r[DATA_WIDTH-1], head.data_r} - {in_data.data_r[DATA_WIDTH-1], in_data.data_r});
    diff_d.data_i = sat16({head.data_i[DATA_WIDTH-1], head.data_i} - {in_data.data_i[DATA_WIDTH-1], in_data.data_i});
    // First half: stash the new sample and release last block's difference from the same slot.
    wr_d       = half ? diff_d : in_data;
    out_data_d = half ? sum_d  : head;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_phase_q <= 1'b0;
      out_idx_q   <= '0;
      for (int i = 0; i < DELAY; i++) mem_q[i] <= '0;
    end else begin
      out_valid_q <= in_valid && (half || primed_q);
      if (in_valid) begin
        cnt_q       <= cnt_q + CW'(1);
        if (cnt_q == CW'(2 * DELAY - 1)) primed_q <= 1'b1;
        mem_q[idx]  <= wr_d;
        out_data_q  <= out_data_d;
        out_phase_q <= ~half;
        out_idx_q   <= idx;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_phase = out_phase_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// Randomized bench for r2sdf_bf_stage (DELAY=4) against a block-level x[n]+-x[n+4] reference model.
module tb_r2sdf_bf_stage;
  import r2sdf_pkg::*;

  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  data_sample_t in_data = '0;
  logic         out_valid;
  data_sample_t out_data;
  logic         out_phase;
  logic [1:0]   out_idx;

  r2sdf_bf_stage #(.DELAY(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_phase(out_phase),
    .out_idx  (out_idx)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  string cur;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", cur, tag, obs, exp);
    end
  endtask

  // Reference model: whole blocks of samples, differences computed once a block completes.
  data_sample_t m_blk [2*D];
  data_sample_t m_diff[D];
  int           m_n;
  bit           m_primed;
  bit           e_vld;
  bit           e_known;
  data_sample_t e_dat;
  bit           e_phase;
  int           e_idx;

  data_sample_t obs_q[$];
  bit           obs_ph_q[$];
  int           obs_idx_q[$];
  int           n_sum, n_diff;

  function automatic logic signed [15:0] sat16(input int v);
    if (v > 32767)  return 16'sd32767;
    if (v < -32768) return -16'sd32768;
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_n = 0; m_primed = 0;
    for (int i = 0; i < 2*D; i++) m_blk[i] = '0;
    for (int i = 0; i < D; i++) m_diff[i] = '0;
    e_vld = 0; e_known = 1; e_dat = '0; e_phase = 0; e_idx = 0;
  endtask

  task automatic model_accept(input data_sample_t b);
    if (m_n < D) begin
      e_dat = m_diff[m_n]; e_phase = 1; e_idx = m_n; e_vld = m_primed;
    end else begin
      e_dat.data_r = sat16(int'(m_blk[m_n-D].data_r) + int'(b.data_r));
      e_dat.data_i = sat16(int'(m_blk[m_n-D].data_i) + int'(b.data_i));
      e_phase = 0; e_idx = m_n - D; e_vld = 1;
    end
    e_known = e_vld;
    m_blk[m_n] = b;
    m_n++;
    if (m_n == 2*D) begin
      for (int i = 0; i < D; i++) begin
        m_diff[i].data_r = sat16(int'(m_blk[i].data_r) - int'(m_blk[i+D].data_r));
        m_diff[i].data_i = sat16(int'(m_blk[i].data_i) - int'(m_blk[i+D].data_i));
      end
      m_n = 0; m_primed = 1;
    end
  endtask

  task automatic step(input bit v, input data_sample_t d, input bit rst);
    in_valid = v; in_data = d; rst_n = !rst;
    @(posedge clk); #1;
    if (rst) model_reset();
    else if (v) model_accept(d);
    else e_vld = 0;
    check("valid", out_valid, e_vld);
    if (e_known) begin
      check("data_r", out_data.data_r, e_dat.data_r);
      check("data_i", out_data.data_i, e_dat.data_i);
      check("phase", out_phase, e_phase);
      check("idx", out_idx, e_idx);
    end
    if (out_valid) begin
      obs_q.push_back(out_data); obs_ph_q.push_back(out_phase); obs_idx_q.push_back(int'(out_idx));
      if (out_phase) n_diff++; else n_sum++;
    end
    in_valid = 0;
    rst_n = 1;
  endtask

  function automatic data_sample_t mk(input int r, input int i);
    data_sample_t s;
    s.data_r = 16'(r); s.data_i = 16'(i);
    return s;
  endfunction

  function automatic data_sample_t rnd();
    return mk(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
  endfunction

  task automatic clear_obs();
    obs_q.delete(); obs_ph_q.delete(); obs_idx_q.delete();
    n_sum = 0; n_diff = 0;
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b1);
    clear_obs();
  endtask

  // Basic stream 1..8 then zero flush; optional imaginary 8..1 and random bubbles.
  task automatic run_basic(input bit bubbles, input bit cplx);
    for (int k = 0; k < 3*D; k++) begin
      if (bubbles)
        while ($urandom_range(0, 2) == 0) step(1'b0, rnd(), 1'b0);
      step(1'b1, mk(k < 2*D ? k + 1 : 0, (cplx && k < 2*D) ? 2*D - k : 0), 1'b0);
    end
  endtask

  task automatic check_table(input int er[2*D], input int ei[2*D]);
    check("n_out", obs_q.size(), 2*D);
    for (int k = 0; k < 2*D && k < obs_q.size(); k++) begin
      check($sformatf("tbl_r%0d", k), obs_q[k].data_r, er[k]);
      check($sformatf("tbl_i%0d", k), obs_q[k].data_i, ei[k]);
      check($sformatf("tbl_ph%0d", k), obs_ph_q[k], k >= D);
      check($sformatf("tbl_idx%0d", k), obs_idx_q[k], k % D);
    end
  endtask

  initial begin
    int basic_r[2*D];
    int zeros  [2*D];
    int cplx_i [2*D];
    int sat_v  [2*D];
    basic_r = '{6, 8, 10, 12, -4, -4, -4, -4};
    zeros   = '{0, 0, 0, 0, 0, 0, 0, 0};
    cplx_i  = '{12, 10, 8, 6, 4, 4, 4, 4};
    sat_v   = '{32767, -32767, -1, 0, 32766, -32768, -32768, 0};

    cur = "reset";
    do_reset();

    cur = "basic";
    run_basic(1'b0, 1'b0);
    check_table(basic_r, zeros);

    cur = "sat";
    do_reset();
    step(1'b1, mk(32767, 32767), 1'b0);
    step(1'b1, mk(-32768, -32768), 1'b0);
    step(1'b1, mk(-32768, -32768), 1'b0);
    step(1'b1, mk(0, 0), 1'b0);
    step(1'b1, mk(1, 1), 1'b0);
    step(1'b1, mk(1, 1), 1'b0);
    step(1'b1, mk(32767, 32767), 1'b0);
    step(1'b1, mk(0, 0), 1'b0);
    for (int k = 0; k < D; k++) step(1'b1, mk(0, 0), 1'b0);
    check_table(sat_v, sat_v);

    cur = "bubbles";
    do_reset();
    run_basic(1'b1, 1'b0);
    check_table(basic_r, zeros);

    cur = "midreset";
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, rnd(), 1'b0);
    step(1'b1, rnd(), 1'b1);
    clear_obs();
    run_basic(1'b0, 1'b0);
    check_table(basic_r, zeros);

    cur = "complex";
    do_reset();
    run_basic(1'b0, 1'b1);
    check_table(basic_r, cplx_i);

    cur = "b2b";
    do_reset();
    for (int k = 0; k < 3*2*D; k++) step(1'b1, rnd(), 1'b0);
    for (int k = 0; k < D; k++) step(1'b1, mk(0, 0), 1'b0);
    check("n_sum", n_sum, 3*D);
    check("n_diff", n_diff, 3*D);
    for (int k = 0; k < D; k++) step(1'b1, mk(0, 0), 1'b0);

    cur = "random";
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, rnd(), 1'b0);
      else if ($urandom_range(0, 99) == 0) step(1'b1, rnd(), 1'b1);
      else step(1'b1, rnd(), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
